mul_datapath_ctrl: RTL and testbench
====================================

MUL_DATAPATH_CTRL -- requirements
Module: mul_datapath_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and product bit width.
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 SHALL have port start, input, 1: request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port data_in, input, WIDTH: shared operand bus carrying multiplicand A, then multiplier B, on consecutive cycles.
REQ-006 SHALL have port Pout, output, WIDTH: product register, modulo 2^WIDTH.
REQ-007 SHALL have port done, output, 1: one-cycle pulse; Pout valid.
REQ-008 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-009 SHALL have port overflow, output, 1: sticky flag; true product exceeded 2^WIDTH-1.

Function
REQ-010 SHALL compute Pout = A*B by repeated addition: one addition of A per cycle, B decremented per addition.
REQ-011 SHALL implement states IDLE, LOAD_A, LOAD_B, RUN, DONE, and no others.
REQ-012 IDLE SHALL move to LOAD_A on an edge where start=1, and otherwise remain in IDLE.
REQ-013 LOAD_A SHALL latch A <= data_in and move to LOAD_B.
REQ-014 LOAD_B SHALL latch B <= data_in, clear Pout to 0, clear overflow, and move to RUN.
REQ-015 RUN with B != 0 SHALL perform Pout <= Pout + A and B <= B - 1, and remain in RUN.
REQ-016 RUN with B == 0 SHALL move to DONE and leave Pout unchanged.
REQ-017 DONE SHALL move to IDLE unconditionally.
REQ-018 done SHALL be 1 exactly while in DONE (one cycle); busy SHALL be 1 in LOAD_A, LOAD_B, RUN and DONE.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge E0+3+B.
REQ-020 Addition SHALL be WIDTH+1 bits wide; Pout keeps the low WIDTH bits; a carry-out of 1 SHALL set overflow.
REQ-021 overflow SHALL stay set until the next LOAD_B or reset.
REQ-022 Pout and overflow SHALL hold their values from DONE through IDLE until the next LOAD_B.
REQ-023 start SHALL be ignored in every state except IDLE; no queuing.
REQ-024 If start is high in the DONE cycle, the block SHALL still pass through IDLE, beginning the next LOAD_A no earlier than one edge after IDLE.
REQ-025 B=0 SHALL give Pout=0 and done two edges after LOAD_B; A=0 SHALL still take B iterations.
REQ-026 data_in SHALL be don't-care in IDLE, RUN and DONE.

Reset
REQ-027 On a rising edge with rst_n=0, the block SHALL force state=IDLE, A=0, B=0, Pout=0, overflow=0, done=0 and busy=0.
REQ-028 Reset SHALL take priority over start and over any state, including mid-RUN; the operation in progress SHALL be abandoned with no done pulse.
REQ-029 After rst_n returns to 1, the first start SHALL be accepted on the following edge.

Verification
REQ-030 A=28, B=4 -> Pout=112, overflow=0, done for one cycle after E0+7, busy low the cycle after.
REQ-031 A=28, B=0 -> Pout=0, done after E0+3; then A=0, B=5 -> Pout=0, done after E0+8.
REQ-032 A=300, B=300 -> Pout=24464 (90000 mod 65536), overflow=1; next op 2*3 -> Pout=6, overflow=0.
REQ-033 rst_n=0 asserted mid-RUN of A=7, B=100 -> next edge all outputs 0, state IDLE, no done pulse; then 7*4 -> 28.
REQ-034 start held at 1 for three back-to-back ops -> each done pulse followed by one IDLE cycle (busy=0); start pulses during busy ignored; Pout correct for each op.

Source files
------------

// File: rtl/mul_datapath_ctrl.sv
// Shift-free multiplier: Pout = A * B built by adding A once per cycle
// while counting B down to zero. A and B arrive on a shared bus on
// consecutive cycles after start is accepted in IDLE.
module mul_datapath_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] Pout,
  output logic             done,
  output logic             busy,
  output logic             overflow
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic             ovf_q, ovf_d;

  // One extra bit so the carry-out of each accumulation is visible.
  logic [WIDTH:0]   sum;

  assign sum = {1'b0, p_q} + {1'b0, a_q};

  // Next-state and datapath updates; everything holds unless a state acts on it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_A;
      end
      LOAD_A: begin
        a_d     = data_in;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        b_d     = data_in;
        p_d     = '0;
        ovf_d   = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        if (b_q != '0) begin
          p_d = sum[WIDTH-1:0];
          b_d = b_q - 1'b1;
          if (sum[WIDTH]) ovf_d = 1'b1;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Pout     = p_q;
  assign overflow = ovf_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mul_datapath_ctrl.sv
// Directed bench for mul_datapath_ctrl: hand-computed products, latency,
// overflow, reset abort and back-to-back operation with start held high.
module tb_mul_datapath_ctrl;

  localparam int unsigned WIDTH = 16;

  logic             clock;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] Pout;
  logic             done;
  logic             busy;
  logic             overflow;

  int unsigned n_checks;
  int unsigned n_errors;

  mul_datapath_ctrl #(.WIDTH(WIDTH)) dut (
    .clock    (clock),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .Pout     (Pout),
    .done     (done),
    .busy     (busy),
    .overflow (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Runs one operation. Entered and left at a negedge while the DUT is in IDLE.
  // hold_start keeps start at 1 throughout; otherwise start is dropped after
  // acceptance and re-pulsed during RUN to show it is ignored.
  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] exp_p, input logic exp_ovf,
                       input bit hold_start, input string tag);
    int unsigned k;
    int unsigned budget;
    bit          seen;
    start = 1'b1;
    @(posedge clock);                 // E0: start sampled in IDLE
    @(negedge clock);
    check_eq({tag, "_busy_load_a"}, busy, 1);
    check_eq({tag, "_done_load_a"}, done, 0);
    data_in = a;
    if (!hold_start) start = 1'b0;
    @(posedge clock);                 // E0+1: A latched
    @(negedge clock);
    data_in = b;
    @(posedge clock);                 // E0+2: B latched
    @(negedge clock);
    data_in = 16'($urandom);
    if (!hold_start) start = 1'b1;    // ignored while busy
    k      = 0;
    seen   = 1'b0;
    budget = 32'(b) + 10;
    while (k < budget && !seen) begin
      @(posedge clock);
      k++;
      @(negedge clock);
      data_in = 16'($urandom);
      if (!hold_start) start = (k % 2 == 1);
      if (done) seen = 1'b1;
    end
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_latency"}, k, 32'(b) + 1);
    check_eq({tag, "_pout"}, Pout, exp_p);
    check_eq({tag, "_ovf"}, overflow, exp_ovf);
    check_eq({tag, "_busy_done"}, busy, 1);
    if (!hold_start) start = 1'b1;    // start during DONE must not skip IDLE
    @(posedge clock);
    @(negedge clock);
    check_eq({tag, "_done_width"}, done, 0);
    check_eq({tag, "_busy_idle"}, busy, 0);
    check_eq({tag, "_pout_hold"}, Pout, exp_p);
    check_eq({tag, "_ovf_hold"}, overflow, exp_ovf);
    if (!hold_start) start = 1'b0;
  endtask

  initial begin
    int unsigned dcount;
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    data_in  = '0;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_pout", Pout, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    rst_n = 1'b1;

    // Start low keeps the block idle
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("idle_busy", busy, 0);

    // 28 * 4
    do_op(16'd28, 16'd4, 16'd112, 1'b0, 1'b0, "a28b4");
    // B = 0 and A = 0 corners
    do_op(16'd28, 16'd0, 16'd0, 1'b0, 1'b0, "a28b0");
    do_op(16'd0, 16'd5, 16'd0, 1'b0, 1'b0, "a0b5");
    // Overflow, then cleared by next operation
    do_op(16'd300, 16'd300, 16'd24464, 1'b1, 1'b0, "a300b300");
    repeat (3) @(negedge clock);
    check_eq("ovf_sticky_idle", overflow, 1);
    check_eq("pout_held_idle", Pout, 24464);
    do_op(16'd2, 16'd3, 16'd6, 1'b0, 1'b0, "a2b3");

    // Reset in the middle of RUN for 7 * 100
    start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start   = 1'b0;
    data_in = 16'd7;
    @(posedge clock);
    @(negedge clock);
    data_in = 16'd100;
    repeat (10) @(posedge clock);
    @(negedge clock);
    check_eq("midrun_busy", busy, 1);
    check_eq("midrun_pout_nonzero", (Pout != 0), 1);
    rst_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq("abort_pout", Pout, 0);
    check_eq("abort_ovf", overflow, 0);
    check_eq("abort_done", done, 0);
    check_eq("abort_busy", busy, 0);
    rst_n  = 1'b1;
    dcount = 0;
    repeat (120) begin
      @(posedge clock);
      @(negedge clock);
      if (done || busy) dcount++;
    end
    check_eq("abort_no_done", dcount, 0);
    do_op(16'd7, 16'd4, 16'd28, 1'b0, 1'b0, "a7b4");

    // Start held high across three back-to-back operations
    do_op(16'd5, 16'd6, 16'd30, 1'b0, 1'b1, "held1");
    do_op(16'd9, 16'd2, 16'd18, 1'b0, 1'b1, "held2");
    do_op(16'd300, 16'd220, 16'd00464, 1'b1, 1'b1, "held3");
    start = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
